shift_add_mult_ctrl: RTL



---
 rtl/shift_add_mult_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-add multiplier: one AND-gated partial-product row per clock.
// Optional macro SHIFT_ADD_EARLY_TERM_EN ends RUN once the remaining multiplier bits are zero.
module shift_add_mult_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   m_sh_q, m_sh_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     q_r_q, q_r_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_iter;

  always_comb begin
`ifdef SHIFT_ADD_EARLY_TERM_EN
    // Stop as soon as no set multiplier bits remain after this shift.
    last_iter = (cnt_q == LastCnt) || ((q_r_q >> 1) == '0);
`else
    last_iter = (cnt_q == LastCnt);
`endif
  end

  always_comb begin
    state_d   = state_q;
    m_sh_d    = m_sh_q;
    product_d = product_q;
    q_r_d     = q_r_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_sh_d    = {{WIDTH{1'b0}}, m};
          q_r_d     = q;
          product_d = '0;
          cnt_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        product_d = product_q + (m_sh_q & {(2*WIDTH){q_r_q[0]}});
        m_sh_d    = m_sh_q << 1;
        q_r_d     = q_r_q >> 1;
        cnt_d     = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      m_sh_q    <= '0;
      product_q <= '0;
      q_r_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_sh_q    <= m_sh_d;
      product_q <= product_d;
      q_r_q     <= q_r_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule
